bias_add_seq: RTL and testbench

Parametrised, loadable bias stage: stores one 18-bit signed bias per lane for each of `GROUPS` output-channel groups and adds the active group's biases to a stream of `N_adder_tree`-lane accumulator words. The result of each add is saturated. It sits between the adder-tree output and the activation/requant stage. It replaces the fixed per-layer constant bias banks with one runtime-configurable block that steps through groups automatically.

---
 rtl/bias_pkg.sv | 34 +++
 rtl/bias_add_seq_if.sv | 47 ++++
 rtl/bias_sat_lane.sv | 39 +++
 rtl/bias_add_seq.sv | 150 +++++++++++++++
 tb/tb_bias_add_seq.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bias_pkg.sv
// -----------------------------------------------------------------------------
// bias_pkg
// Shared definitions for the loadable bias stage: default lane width,
// saturation bounds, the sequencer state encoding and a saturating add.
// No ports (package).
// -----------------------------------------------------------------------------
package bias_pkg;

   localparam int BIAS_W = 18;

   localparam logic signed [BIAS_W-1:0] BIAS_MAX = {1'b0, {(BIAS_W-1){1'b1}}};
   localparam logic signed [BIAS_W-1:0] BIAS_MIN = {1'b1, {(BIAS_W-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } state_t;

   // Sum formed one bit wider; a disagreement between the two top bits means
   // the true result left the representable range.
   function automatic logic signed [BIAS_W-1:0] sat_add(
      input logic signed [BIAS_W-1:0] a,
      input logic signed [BIAS_W-1:0] b
   );
      logic signed [BIAS_W:0] s;
      s = {a[BIAS_W-1], a} + {b[BIAS_W-1], b};
      if (s[BIAS_W] != s[BIAS_W-1])
         sat_add = s[BIAS_W] ? BIAS_MIN : BIAS_MAX;
      else
         sat_add = s[BIAS_W-1:0];
   endfunction

endpackage

// File: rtl/bias_add_seq_if.sv
// -----------------------------------------------------------------------------
// bias_add_seq_if
// Bundles the configuration port, the input/output beat streams and the
// pass status of bias_add_seq.
//   master : the side that loads biases, starts passes, feeds beats and
//            drains results (testbench / surrounding datapath)
//   slave  : the bias stage itself
// -----------------------------------------------------------------------------
interface bias_add_seq_if
   import bias_pkg::*;
#(
   parameter int N_adder_tree = 16,
   parameter int W            = BIAS_W,
   parameter int GW           = 2,
   parameter int LW           = 4
);

   logic                      cfg_we;
   logic [GW-1:0]             cfg_group;
   logic [LW-1:0]             cfg_lane;
   logic [W-1:0]              cfg_data;
   logic                      start;
   logic                      in_valid;
   logic                      in_ready;
   logic [N_adder_tree*W-1:0] in_data;
   logic                      in_last;
   logic                      out_valid;
   logic                      out_ready;
   logic [N_adder_tree*W-1:0] out_data;
   logic                      out_last;
   logic [GW-1:0]             group_idx;
   logic                      busy;
   logic                      done;

   modport master (
      output cfg_we, cfg_group, cfg_lane, cfg_data, start,
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_last, group_idx, busy, done
   );

   modport slave (
      input  cfg_we, cfg_group, cfg_lane, cfg_data, start,
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, out_last, group_idx, busy, done
   );

endinterface

// File: rtl/bias_sat_lane.sv
// -----------------------------------------------------------------------------
// bias_sat_lane
// One lane of the bias stage: signed add of accumulator word and bias,
// clamped to the W-bit signed range. Purely combinational.
//   a : signed accumulator word
//   b : signed bias
//   y : saturated sum
// -----------------------------------------------------------------------------
module bias_sat_lane
   import bias_pkg::*;
#(
   parameter int W = BIAS_W
) (
   input  logic signed [W-1:0] a,
   input  logic signed [W-1:0] b,
   output logic signed [W-1:0] y
);

   function automatic logic signed [W-1:0] sat_w(
      input logic signed [W-1:0] x0,
      input logic signed [W-1:0] x1
   );
      logic signed [W:0] s;
      s = {x0[W-1], x0} + {x1[W-1], x1};
      if (s[W] != s[W-1])
         sat_w = s[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      else
         sat_w = s[W-1:0];
   endfunction

   // The shared package function covers the default width; other widths use
   // the local equivalent.
   if (W == BIAS_W) begin : g_pkg
      assign y = sat_add(a, b);
   end else begin : g_gen
      assign y = sat_w(a, b);
   end

endmodule

// File: rtl/bias_add_seq.sv
// -----------------------------------------------------------------------------
// bias_add_seq
// Runtime-loadable bias stage between the adder tree and requantisation.
// Holds one signed bias per lane for each of GROUPS channel groups, adds the
// active group's biases to every accepted beat with saturation, and steps to
// the next group after each in_last beat. After the last group's final beat
// it drains the output register and pulses done.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : cfg_* bias load port, start, in_* / out_* valid-ready streams,
//              group_idx, busy, done (see bias_add_seq_if)
// -----------------------------------------------------------------------------
module bias_add_seq
   import bias_pkg::*;
#(
   parameter int N_adder_tree = 16,
   parameter int W            = BIAS_W,
   parameter int GROUPS       = 4,
   parameter int GW           = (GROUPS > 1) ? $clog2(GROUPS) : 1,
   parameter int LW           = (N_adder_tree > 1) ? $clog2(N_adder_tree) : 1
) (
   input  logic          clk,
   input  logic          rst,
   bias_add_seq_if.slave bus
);

   localparam logic [GW-1:0] LAST_GRP = GW'(GROUPS - 1);

   state_t                    state;
   state_t                    state_nxt;
   logic [GW-1:0]             grp;
   logic signed [W-1:0]       bias_mem [GROUPS][N_adder_tree];

   logic [N_adder_tree*W-1:0] sum_p0;
   logic [N_adder_tree*W-1:0] data_p1;
   logic                      last_p1;
   logic                      vld_p1;

   logic                      in_ready_c;
   logic                      done_c;
   logic                      busy_c;
   logic                      accept;
   logic                      xfer;
   logic                      last_grp;
   logic                      cfg_ok;

   assign accept   = bus.in_valid && in_ready_c;
   assign xfer     = vld_p1 && bus.out_ready;
   assign last_grp = (grp == LAST_GRP);
   // Guard against out-of-range indices when GROUPS or N_adder_tree is not a
   // power of two.
   assign cfg_ok   = (state == IDLE) && bus.cfg_we &&
                     (int'(bus.cfg_group) < GROUPS) &&
                     (int'(bus.cfg_lane) < N_adder_tree);

   // Bias memory
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int g = 0; g < GROUPS; g++)
            for (int k = 0; k < N_adder_tree; k++)
               bias_mem[g][k] <= '0;
      end else if (cfg_ok) begin
         bias_mem[bus.cfg_group][bus.cfg_lane] <= bus.cfg_data;
      end
   end

   // FSM: state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // FSM: next state
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start) state_nxt = RUN;
         RUN:     if (accept && bus.in_last && last_grp) state_nxt = FLUSH;
         FLUSH:   if (xfer) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      in_ready_c = 1'b0;
      done_c     = 1'b0;
      busy_c     = 1'b0;
      case (state)
         RUN: begin
            in_ready_c = !vld_p1 || bus.out_ready;
            busy_c     = 1'b1;
         end
         FLUSH: begin
            done_c = xfer;
            busy_c = !xfer;
         end
         default: ;
      endcase
   end

   // Group pointer: advances on the in_last beat so the next beat already
   // sees the new group.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         grp <= '0;
      else if (state == IDLE && bus.start)
         grp <= '0;
      else if (accept && bus.in_last && !last_grp)
         grp <= grp + 1'b1;
      else if (done_c)
         grp <= '0;
   end

   // Stage p0: per-lane saturating add
   for (genvar k = 0; k < N_adder_tree; k++) begin : g_lane
      logic signed [W-1:0] in_k;
      logic signed [W-1:0] sum_k;
      assign in_k = bus.in_data[W*k +: W];
      bias_sat_lane #(.W(W)) u_lane (
         .a (in_k),
         .b (bias_mem[grp][k]),
         .y (sum_k)
      );
      assign sum_p0[W*k +: W] = sum_k;
   end

   // Stage p1: single output register, refilled in the same cycle it drains
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1  <= 1'b0;
         data_p1 <= '0;
         last_p1 <= 1'b0;
      end else if (accept) begin
         vld_p1  <= 1'b1;
         data_p1 <= sum_p0;
         last_p1 <= bus.in_last;
      end else if (xfer) begin
         vld_p1  <= 1'b0;
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = vld_p1;
   assign bus.out_data  = data_p1;
   assign bus.out_last  = last_p1;
   assign bus.group_idx = grp;
   assign bus.busy      = busy_c;
   assign bus.done      = done_c;

endmodule

// File: tb/tb_bias_add_seq.sv
// -----------------------------------------------------------------------------
// tb_bias_add_seq
// Self-checking bench for bias_add_seq: a GROUPS=1 instance driven from a
// vector table (single-beat passes, saturation corners) and a GROUPS=4
// instance driven by hand-written multi-cycle sequences.
// -----------------------------------------------------------------------------
module tb_bias_add_seq;
   import bias_pkg::*;

   localparam int N  = 16;
   localparam int WD = 18;

   logic clk;
   logic rst1;
   logic rst4;

   int tests;
   int fails;

   int tb_bias4 [4][N];

   bias_add_seq_if #(.N_adder_tree(N), .W(WD), .GW(1), .LW(4)) if1 ();
   bias_add_seq_if #(.N_adder_tree(N), .W(WD), .GW(2), .LW(4)) if4 ();

   bias_add_seq #(.N_adder_tree(N), .W(WD), .GROUPS(1)) dut1 (
      .clk (clk),
      .rst (rst1),
      .bus (if1)
   );

   bias_add_seq #(.N_adder_tree(N), .W(WD), .GROUPS(4)) dut4 (
      .clk (clk),
      .rst (rst4),
      .bus (if4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no end of test, required finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      int b0; int b1; int i0; int i1; int e0; int e1;
   } vec_t;

   vec_t tbl [6];

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d required %0d", nm, act, exp);
      end
   endtask

   function automatic int lane_of(input logic [N*WD-1:0] d, input int k);
      logic signed [WD-1:0] v;
      v = d[WD*k +: WD];
      return int'(v);
   endfunction

   function automatic int tsat(input int s);
      if (s > 131071)  return 131071;
      if (s < -131072) return -131072;
      return s;
   endfunction

   task automatic chk_idle(input string tag, input logic ir, input logic ov,
                           input logic [N*WD-1:0] od, input logic ol,
                           input int gi, input logic bz, input logic dn);
      chk({tag, "_in_ready"},  ir, 0);
      chk({tag, "_out_valid"}, ov, 0);
      chk({tag, "_out_data0"}, int'(od == '0), 1);
      chk({tag, "_out_last"},  ol, 0);
      chk({tag, "_group_idx"}, gi, 0);
      chk({tag, "_busy"},      bz, 0);
      chk({tag, "_done"},      dn, 0);
   endtask

   task automatic cfg4(input int g, input int l, input int v);
      if4.cfg_we    = 1'b1;
      if4.cfg_group = 2'(g);
      if4.cfg_lane  = 4'(l);
      if4.cfg_data  = 18'(v);
      @(posedge clk); #1;
      if4.cfg_we    = 1'b0;
      tb_bias4[g][l] = v;
   endtask

   // One full 4-group pass of 8 beats (2 per group) on dut4, checked against
   // the bench's bias model. Optional 3-cycle out_ready stall and an
   // in-pass config write + start that must be ignored.
   task automatic run_pass(input string tag, input int base, input bit stall,
                           input bit disturb);
      int sent, got, dones, cyc, g, v;
      int q0[$], q1[$], q15[$], ql[$];
      logic [N*WD-1:0] d, prev_d;
      bit prev_hold, exp_done, xf;
      sent = 0; got = 0; dones = 0; cyc = 0;
      prev_hold = 1'b0; prev_d = '0; d = '0;
      if4.start = 1'b1;
      @(posedge clk); #1;
      if4.start = 1'b0;
      chk({tag, "_busy_rise"}, if4.busy, 1);
      while (got < 8 && cyc < 200) begin
         for (int k = 0; k < N; k++) begin
            v = (k == 0) ? base : (k == 1) ? sent * 5 - 7 : k * 100 - sent;
            d[WD*k +: WD] = 18'(v);
         end
         if4.in_valid  = (sent < 8);
         if4.in_data   = d;
         if4.in_last   = (sent % 2 == 1);
         if4.out_ready = !(stall && cyc >= 4 && cyc < 7);
         if (disturb && cyc == 3) begin
            if4.cfg_we    = 1'b1;
            if4.cfg_group = 2'd0;
            if4.cfg_lane  = 4'd0;
            if4.cfg_data  = 18'(999);
            if4.start     = 1'b1;
         end else begin
            if4.cfg_we = 1'b0;
            if4.start  = 1'b0;
         end
         #1;
         if (prev_hold)
            chk({tag, "_hold"}, int'(if4.out_data == prev_d), 1);
         if (if4.out_valid && !if4.out_ready)
            chk({tag, "_stall_in_ready"}, if4.in_ready, 0);
         xf = if4.out_valid && if4.out_ready;
         exp_done = 1'b0;
         if (xf) begin
            if (q0.size() == 0) begin
               chk({tag, "_spurious_beat"}, 1, 0);
            end else begin
               chk({tag, "_lane0"},  lane_of(if4.out_data, 0),  q0.pop_front());
               chk({tag, "_lane1"},  lane_of(if4.out_data, 1),  q1.pop_front());
               chk({tag, "_lane15"}, lane_of(if4.out_data, 15), q15.pop_front());
               chk({tag, "_out_last"}, if4.out_last, ql.pop_front());
            end
            got++;
            exp_done = (got == 8);
         end
         chk({tag, "_done"}, if4.done, exp_done);
         chk({tag, "_busy"}, if4.busy, !exp_done);
         if (if4.done) dones++;
         if (if4.in_valid && if4.in_ready) begin
            g = sent / 2;
            chk({tag, "_group_idx"}, if4.group_idx, g);
            q0.push_back(tsat(lane_of(d, 0) + tb_bias4[g][0]));
            q1.push_back(tsat(lane_of(d, 1) + tb_bias4[g][1]));
            q15.push_back(tsat(lane_of(d, 15) + tb_bias4[g][15]));
            ql.push_back(sent % 2);
            sent++;
         end
         prev_hold = if4.out_valid && !if4.out_ready;
         prev_d    = if4.out_data;
         @(posedge clk); #1;
         cyc++;
      end
      if4.in_valid = 1'b0;
      if4.in_last  = 1'b0;
      if4.cfg_we   = 1'b0;
      if4.start    = 1'b0;
      chk({tag, "_beats_out"}, got, 8);
      chk({tag, "_done_count"}, dones, 1);
      chk({tag, "_post_busy"}, if4.busy, 0);
      chk({tag, "_post_group"}, if4.group_idx, 0);
      chk({tag, "_post_in_ready"}, if4.in_ready, 0);
      chk({tag, "_post_out_valid"}, if4.out_valid, 0);
      chk({tag, "_post_done"}, if4.done, 0);
   endtask

   initial begin
      logic [N*WD-1:0] d1;
      int dones;
      tests = 0;
      fails = 0;
      for (int g = 0; g < 4; g++)
         for (int k = 0; k < N; k++)
            tb_bias4[g][k] = 0;

      //        b0        b1        i0        i1        e0        e1
      tbl[0] = '{-400,     3348,     1000,     0,        600,      3348};
      tbl[1] = '{3348,     0,        131000,   0,        131071,   0};
      tbl[2] = '{-400,     0,        -131000,  0,        -131072,  0};
      tbl[3] = '{0,        -1,       131071,   -131072,  131071,   -131072};
      tbl[4] = '{131071,   131071,   131071,   1,        131071,   131071};
      tbl[5] = '{-131072,  -131072,  -131072,  0,        -131072,  -131072};

      {if1.cfg_we, if1.start, if1.in_valid, if1.in_last, if1.out_ready} = '0;
      if1.cfg_group = '0; if1.cfg_lane = '0; if1.cfg_data = '0; if1.in_data = '0;
      {if4.cfg_we, if4.start, if4.in_valid, if4.in_last, if4.out_ready} = '0;
      if4.cfg_group = '0; if4.cfg_lane = '0; if4.cfg_data = '0; if4.in_data = '0;

      rst1 = 1'b1;
      rst4 = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk_idle("rst1", if1.in_ready, if1.out_valid, if1.out_data, if1.out_last,
               if1.group_idx, if1.busy, if1.done);
      chk_idle("rst4", if4.in_ready, if4.out_valid, if4.out_data, if4.out_last,
               if4.group_idx, if4.busy, if4.done);
      rst1 = 1'b0;
      rst4 = 1'b0;
      @(posedge clk); #1;

      // Single-group instance: write lane0, then lane1 together with start.
      for (int i = 0; i < 6; i++) begin
         if1.cfg_we    = 1'b1;
         if1.cfg_group = 1'b0;
         if1.cfg_lane  = 4'd0;
         if1.cfg_data  = 18'(tbl[i].b0);
         @(posedge clk); #1;
         if1.cfg_lane  = 4'd1;
         if1.cfg_data  = 18'(tbl[i].b1);
         if1.start     = 1'b1;
         @(posedge clk); #1;
         if1.cfg_we    = 1'b0;
         if1.start     = 1'b0;
         chk($sformatf("v%0d_busy_run", i), if1.busy, 1);
         d1 = '0;
         d1[0 +: WD]     = 18'(tbl[i].i0);
         d1[WD +: WD]    = 18'(tbl[i].i1);
         d1[WD*15 +: WD] = 18'(-5);
         if1.in_data   = d1;
         if1.in_valid  = 1'b1;
         if1.in_last   = 1'b1;
         if1.out_ready = 1'b1;
         #1;
         chk($sformatf("v%0d_in_ready", i), if1.in_ready, 1);
         @(posedge clk); #1;
         if1.in_valid = 1'b0;
         if1.in_last  = 1'b0;
         #1;
         chk($sformatf("v%0d_out_valid", i), if1.out_valid, 1);
         chk($sformatf("v%0d_lane0", i), lane_of(if1.out_data, 0), tbl[i].e0);
         chk($sformatf("v%0d_lane1", i), lane_of(if1.out_data, 1), tbl[i].e1);
         chk($sformatf("v%0d_lane15", i), lane_of(if1.out_data, 15), -5);
         chk($sformatf("v%0d_out_last", i), if1.out_last, 1);
         chk($sformatf("v%0d_done", i), if1.done, 1);
         chk($sformatf("v%0d_busy_fall", i), if1.busy, 0);
         chk($sformatf("v%0d_flush_in_ready", i), if1.in_ready, 0);
         @(posedge clk); #1;
         chk($sformatf("v%0d_done_clr", i), if1.done, 0);
         chk($sformatf("v%0d_idle_valid", i), if1.out_valid, 0);
         chk($sformatf("v%0d_idle_busy", i), if1.busy, 0);
      end

      // Four-group instance: lane0 bias 10*g, group stepping with input 0.
      for (int g = 0; g < 4; g++) cfg4(g, 0, 10 * g);
      run_pass("grp", 0, 1'b0, 1'b0);
      run_pass("bp", 1234, 1'b1, 1'b0);
      run_pass("dis", -50, 1'b0, 1'b1);
      run_pass("post_dis", 0, 1'b0, 1'b0);

      // Reset in the middle of group 2: pass abandoned, memory cleared.
      dones = 0;
      if4.out_ready = 1'b1;
      if4.start = 1'b1;
      @(posedge clk); #1;
      if4.start = 1'b0;
      for (int c = 0; c < 5; c++) begin
         d1 = '0;
         for (int k = 0; k < N; k++) d1[WD*k +: WD] = 18'(50 + c);
         if4.in_data  = d1;
         if4.in_valid = 1'b1;
         if4.in_last  = (c % 2 == 1);
         #1;
         if (if4.done) dones++;
         @(posedge clk); #1;
      end
      if4.in_valid = 1'b0;
      if4.in_last  = 1'b0;
      chk("mid_group_idx", if4.group_idx, 2);
      chk("mid_out_valid", if4.out_valid, 1);
      chk("mid_lane0", lane_of(if4.out_data, 0), 54 + 20);
      #2;
      rst4 = 1'b1;
      #1;
      chk_idle("midrst", if4.in_ready, if4.out_valid, if4.out_data, if4.out_last,
               if4.group_idx, if4.busy, if4.done);
      #2;
      rst4 = 1'b0;
      chk("midrst_no_done", dones, 0);
      for (int g = 0; g < 4; g++)
         for (int k = 0; k < N; k++)
            tb_bias4[g][k] = 0;
      @(posedge clk); #1;
      chk("after_rst_busy", if4.busy, 0);
      run_pass("fresh", 77, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
